sprite_scheduler: RTL and testbench
===================================

SPRITE_SCHEDULER -- requirements
Module: sprite_scheduler

Interface
REQ-001 clk  in  1  single clock; all logic on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 pix_valid  in  1  pixel coordinate valid this cycle.
REQ-004 x, y  in  10 each  display coordinate of the current pixel.
REQ-005 frame_start  in  1  one-cycle pulse at start of the vertical blank.
REQ-006 cfg_valid / cfg_ready  in / out  1 / 1  configuration write handshake.
REQ-007 cfg_slot  in  2  target slot, 0..3.
REQ-008 cfg_px, cfg_py  in  10 each  sprite top-left position.
REQ-009 cfg_img  in  2  image index into the shared ROM.
REQ-010 cfg_en  in  1  slot enable.
REQ-011 rom_rd, rom_addr  out  1, 15  shared sprite ROM read strobe and word address.
REQ-012 rom_data  in  24  ROM word {r,g,b}, valid exactly 1 cycle after rom_rd.
REQ-013 out_valid, red, green, blue  out  1, 8, 8, 8  pixel result.
REQ-014 armed  out  1  high when the shadow configuration differs from the active configuration.

Function
REQ-015 Constants: IMG_W = IMG_H = 70; BG = (45,120,135); KEY = (255,255,255).
REQ-016 Four slots; each holds a shadow set {px,py,img,en} and an active set.
REQ-017 A cfg write occurs when cfg_valid & cfg_ready; it updates the shadow set of cfg_slot only.
REQ-018 cfg_ready is 1 except in a frame_start cycle, when it is 0.
REQ-019 On frame_start, all shadow sets copy to the active sets in one cycle.
REQ-020 A cfg_valid held through a frame_start cycle is accepted on the next cycle and goes into the shadow set, so it takes effect in the following frame.
REQ-021 The control FSM has three states:
  - IDLE: no enabled active slot.
  - ARMED: shadow differs from active.
  - RUN: active has at least one enabled slot and shadow equals active.
REQ-022 FSM transitions:
  - A cfg write moves IDLE or RUN to ARMED.
  - frame_start moves ARMED to RUN if any active slot ends up enabled, otherwise to IDLE.
  - armed = (state == ARMED).
REQ-023 Hit test: slot s hits when en, x >= px, x < px+70, y >= py, y < py+70. Sums are computed in 11 bits with no wrap, so sprites past x=639 or y=479 are clipped, not wrapped.
REQ-024 Arbitration: the lowest-numbered hitting slot wins, and only the winner generates a ROM read.
REQ-025 Pipeline stages, total latency fixed at 2 cycles:
  - Stage 0: hit test and winner select.
  - Stage 1: rom_rd = pix_valid & hit; rom_addr = img*4900 + (y-py)*70 + (x-px).
  - Stage 2: colour select.
REQ-026 out_valid equals pix_valid delayed 2 cycles; bubbles (pix_valid = 0) propagate and produce no rom_rd.
REQ-027 Colour select:
  - No hit, or state IDLE: output BG.
  - Hit and rom_data == KEY: output BG (transparent).
  - Otherwise: output rom_data.
REQ-028 rom_rd is never asserted in IDLE, and at most once per cycle.
REQ-029 In ARMED, pixels use the active set; the shadow set never affects the pixel path.
REQ-030 red, green and blue are registered and hold their last value while out_valid = 0.

Reset
REQ-031 On rst, regardless of any in-flight pixel, the following are cleared:
  - State goes to IDLE.
  - All shadow and active sets clear (en = 0, positions 0, img 0).
  - Pipeline valids clear.
REQ-032 Reset output values:
  - out_valid = 0, rom_rd = 0, rom_addr = 0, armed = 0, cfg_ready = 1.
  - red/green/blue = BG.
REQ-033 No output pulse derived from a pre-reset pixel appears after rst is released.

Verification
REQ-034 Reset, then pix_valid with x=10, y=10 -> out_valid 2 cycles later with (45,120,135); rom_rd stays 0.
REQ-035 Write slot0 {px=200, py=100, img=1, en=1}, then frame_start, then pixel (205,103) -> rom_addr = 4900 + 3*70 + 5 = 5115. rom_data = 0x102030 -> output (16,32,48) 2 cycles after the pixel.
REQ-036 Slots 0 and 1 both cover (250,120) -> only the slot 0 address is issued. rom_data = 0xFFFFFF -> output BG.
REQ-037 cfg_valid asserted in the same cycle as frame_start -> cfg_ready = 0 that cycle; write accepted next cycle; armed = 1 until the next frame_start; pixels still use the old configuration.
REQ-038 Slot at px=600 -> pixel x=639 hits with column 39; pixel x=0, which would be column 40 only under wrap, does not hit.
REQ-039 Assert rst in the middle of a burst of pix_valid -> no out_valid or rom_rd for 2 cycles after release, and state = IDLE.

Source files
------------

// File: rtl/sprite_scheduler_if.sv
// Bundle of pixel, configuration, sprite-ROM and colour-result signals for sprite_scheduler.
interface sprite_scheduler_if;
  logic        pix_valid;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        frame_start;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_slot;
  logic [9:0]  cfg_px;
  logic [9:0]  cfg_py;
  logic [1:0]  cfg_img;
  logic        cfg_en;
  logic        rom_rd;
  logic [14:0] rom_addr;
  logic [23:0] rom_data;
  logic        out_valid;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        armed;

  modport master (
    output pix_valid, x, y, frame_start, cfg_valid, cfg_slot, cfg_px, cfg_py,
           cfg_img, cfg_en, rom_data,
    input  cfg_ready, rom_rd, rom_addr, out_valid, red, green, blue, armed
  );

  modport slave (
    input  pix_valid, x, y, frame_start, cfg_valid, cfg_slot, cfg_px, cfg_py,
           cfg_img, cfg_en, rom_data,
    output cfg_ready, rom_rd, rom_addr, out_valid, red, green, blue, armed
  );
endinterface

// File: rtl/sprite_scheduler.sv
// Four-slot 70x70 sprite overlay: double-buffered slot config, lowest-slot-wins hit test,
// shared ROM fetch and colour-key transparency with a fixed 2-cycle pixel latency.
module sprite_scheduler (
  input logic              clk,
  input logic              rst,
  sprite_scheduler_if.slave bus
);
  localparam logic [10:0] IMG_DIM = 11'd70;
  localparam logic [23:0] BG      = 24'h2D7887;
  localparam logic [23:0] KEY     = 24'hFFFFFF;

  typedef struct packed {
    logic [9:0] px;
    logic [9:0] py;
    logic [1:0] img;
    logic       en;
  } slot_t;

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t      state;
  slot_t       shadow [4];
  slot_t       active [4];
  logic        cfg_wr;
  logic        any_shadow_en;
  logic        hit;
  logic [1:0]  win;
  slot_t       sel;
  logic [9:0]  dx;
  logic [9:0]  dy;
  logic [14:0] addr_next;
  logic        fetch;
  logic        v1;
  logic        rd_q;
  logic [14:0] addr_q;
  logic        ov_q;
  logic [23:0] rgb_q;

  assign bus.cfg_ready = ~bus.frame_start;
  assign cfg_wr        = bus.cfg_valid & ~bus.frame_start;
  assign bus.armed     = (state == ARMED);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (cfg_wr)
        shadow[bus.cfg_slot] <= {bus.cfg_px, bus.cfg_py, bus.cfg_img, bus.cfg_en};
      if (bus.frame_start)
        for (int unsigned i = 0; i < 4; i++) active[i] <= shadow[i];
    end
  end

  always_comb begin
    any_shadow_en = 1'b0;
    for (int unsigned i = 0; i < 4; i++) any_shadow_en = any_shadow_en | shadow[i].en;
  end

  // cfg_wr and frame_start are mutually exclusive, so ARMED is left only via frame_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, RUN: if (cfg_wr) state <= ARMED;
        ARMED:     if (bus.frame_start) state <= any_shadow_en ? RUN : IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // Bounds are compared in 11 bits so sprites near the right/bottom edge clip instead of wrapping.
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!hit && active[i].en &&
          {1'b0, bus.x} >= {1'b0, active[i].px} &&
          {1'b0, bus.x} <  {1'b0, active[i].px} + IMG_DIM &&
          {1'b0, bus.y} >= {1'b0, active[i].py} &&
          {1'b0, bus.y} <  {1'b0, active[i].py} + IMG_DIM) begin
        hit = 1'b1;
        win = i[1:0];
      end
    end
  end

  assign sel       = active[win];
  assign dx        = bus.x - sel.px;
  assign dy        = bus.y - sel.py;
  assign addr_next = 15'(sel.img) * 15'd4900 + 15'(dy) * 15'd70 + 15'(dx);
  assign fetch     = bus.pix_valid & hit & (state != IDLE);

  // rom_data is sampled on the edge that closes the rom_rd cycle, giving 2 cycles pixel-to-colour.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= '0;
      ov_q   <= 1'b0;
      rgb_q  <= BG;
    end else begin
      v1   <= bus.pix_valid;
      rd_q <= fetch;
      if (fetch) addr_q <= addr_next;
      ov_q <= v1;
      if (v1) rgb_q <= (rd_q && bus.rom_data != KEY) ? bus.rom_data : BG;
    end
  end

  assign bus.rom_rd    = rd_q;
  assign bus.rom_addr  = addr_q;
  assign bus.out_valid = ov_q;
  assign bus.red       = rgb_q[23:16];
  assign bus.green     = rgb_q[15:8];
  assign bus.blue      = rgb_q[7:0];
endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler with a behavioural ROM answering each read before the next edge.
module tb_sprite_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   rd_count = 0;
  logic [23:0] rom_word = 24'h0;

  localparam logic [31:0] BG = 32'h2D7887;

  sprite_scheduler_if bus ();

  sprite_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    bus.rom_data = bus.rom_rd ? rom_word : 24'h0;
    if (bus.rom_rd === 1'b1) rd_count++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rgb();
    return {8'h0, bus.red, bus.green, bus.blue};
  endfunction

  task automatic cfg_write(input logic [1:0] slot, input logic [9:0] px, input logic [9:0] py,
                           input logic [1:0] img, input logic en);
    bus.cfg_slot  = slot;
    bus.cfg_px    = px;
    bus.cfg_py    = py;
    bus.cfg_img   = img;
    bus.cfg_en    = en;
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic frame;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic pix_check(input string tag, input logic [9:0] px, input logic [9:0] py,
                           input logic exp_rd, input logic [14:0] exp_addr,
                           input logic [23:0] word, input logic [31:0] exp_rgb);
    bus.pix_valid = 1'b1;
    bus.x = px;
    bus.y = py;
    rom_word = word;
    tick();
    bus.pix_valid = 1'b0;
    chk({tag, "_rd"}, 32'(bus.rom_rd), 32'(exp_rd));
    if (exp_rd) chk({tag, "_addr"}, 32'(bus.rom_addr), 32'(exp_addr));
    chk({tag, "_ov_early"}, 32'(bus.out_valid), 32'd0);
    tick();
    chk({tag, "_ov"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_rgb"}, rgb(), exp_rgb);
  endtask

  initial begin
    int rd_before;
    bus.pix_valid = 1'b0; bus.x = '0; bus.y = '0; bus.frame_start = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_slot = '0; bus.cfg_px = '0; bus.cfg_py = '0;
    bus.cfg_img = '0; bus.cfg_en = 1'b0; bus.rom_data = '0;

    tick(); tick();
    chk("rst_ov", 32'(bus.out_valid), 32'd0);
    chk("rst_rd", 32'(bus.rom_rd), 32'd0);
    chk("rst_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_armed", 32'(bus.armed), 32'd0);
    chk("rst_ready", 32'(bus.cfg_ready), 32'd1);
    chk("rst_rgb", rgb(), BG);
    rst = 1'b0;
    tick();

    pix_check("idle_px", 10'd10, 10'd10, 1'b0, 15'd0, 24'h123456, BG);
    chk("idle_rdcnt", 32'(rd_count), 32'd0);

    cfg_write(2'd0, 10'd200, 10'd100, 2'd1, 1'b1);
    chk("wr0_armed", 32'(bus.armed), 32'd1);
    frame();
    chk("fs0_armed", 32'(bus.armed), 32'd0);
    pix_check("s0_px", 10'd205, 10'd103, 1'b1, 15'd5115, 24'h102030, 32'h102030);
    tick();
    chk("hold_ov", 32'(bus.out_valid), 32'd0);
    chk("hold_rgb", rgb(), 32'h102030);

    cfg_write(2'd1, 10'd240, 10'd110, 2'd2, 1'b1);
    frame();
    rd_before = rd_count;
    pix_check("ovl_px", 10'd250, 10'd120, 1'b1, 15'd6350, 24'hFFFFFF, BG);
    chk("ovl_one_rd", 32'(rd_count - rd_before), 32'd1);
    pix_check("s1_px", 10'd300, 10'd150, 1'b1, 15'd12660, 24'hABCDEF, 32'hABCDEF);

    bus.cfg_slot = 2'd2; bus.cfg_px = 10'd0; bus.cfg_py = 10'd0;
    bus.cfg_img = 2'd3; bus.cfg_en = 1'b1; bus.cfg_valid = 1'b1;
    bus.frame_start = 1'b1;
    #1;
    chk("fs_ready_low", 32'(bus.cfg_ready), 32'd0);
    tick();
    bus.frame_start = 1'b0;
    #1;
    chk("fs_ready_back", 32'(bus.cfg_ready), 32'd1);
    chk("fs_not_armed", 32'(bus.armed), 32'd0);
    tick();
    bus.cfg_valid = 1'b0;
    chk("late_wr_armed", 32'(bus.armed), 32'd1);
    pix_check("old_cfg_px", 10'd10, 10'd10, 1'b0, 15'd0, 24'h0A0B0C, BG);
    chk("still_armed", 32'(bus.armed), 32'd1);
    frame();
    chk("applied_armed", 32'(bus.armed), 32'd0);
    pix_check("new_cfg_px", 10'd10, 10'd10, 1'b1, 15'd15410, 24'h010203, 32'h010203);

    cfg_write(2'd2, 10'd0, 10'd0, 2'd3, 1'b0);
    cfg_write(2'd3, 10'd600, 10'd0, 2'd0, 1'b1);
    frame();
    pix_check("clip_hit", 10'd639, 10'd5, 1'b1, 15'd389, 24'h445566, 32'h445566);
    pix_check("clip_nowrap", 10'd0, 10'd5, 1'b0, 15'd0, 24'h445566, BG);
    pix_check("edge_row69", 10'd200, 10'd169, 1'b1, 15'd9730, 24'h778899, 32'h778899);
    pix_check("edge_col69", 10'd269, 10'd100, 1'b1, 15'd4969, 24'h112233, 32'h112233);
    pix_check("edge_row70", 10'd200, 10'd170, 1'b0, 15'd0, 24'h778899, BG);

    rom_word = 24'h556677;
    bus.pix_valid = 1'b1; bus.x = 10'd205; bus.y = 10'd103;
    tick(); tick();
    chk("burst_rd", 32'(bus.rom_rd), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.pix_valid = 1'b0;
    chk("mid_rst_ov", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_rd", 32'(bus.rom_rd), 32'd0);
    chk("mid_rst_rgb", rgb(), BG);
    tick();
    chk("post_rst1_ov", 32'(bus.out_valid), 32'd0);
    chk("post_rst1_rd", 32'(bus.rom_rd), 32'd0);
    tick();
    chk("post_rst2_ov", 32'(bus.out_valid), 32'd0);
    chk("post_rst2_rd", 32'(bus.rom_rd), 32'd0);
    chk("post_rst_armed", 32'(bus.armed), 32'd0);
    pix_check("post_rst_px", 10'd205, 10'd103, 1'b0, 15'd0, 24'h556677, BG);

    cfg_write(2'd0, 10'd200, 10'd100, 2'd1, 1'b0);
    chk("dis_armed", 32'(bus.armed), 32'd1);
    frame();
    chk("dis_idle", 32'(bus.armed), 32'd0);
    pix_check("dis_px", 10'd205, 10'd103, 1'b0, 15'd0, 24'h556677, BG);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
